// File: rtl/fifo_uart_tx_drain_if.sv
// fifo_uart_tx_drain_if: FIFO read-side bundle between a 32-bit word FIFO and its UART drain.
// Latency: none, wires only. The pop is a single-cycle RD strobe. Data is registered in the FIFO and valid the next cycle.
// Backpressure: the drain requests a pop only when EN is high and EMPTY is low, so no pop is ever lost.
// Signals:
//   EN         - shared fetch enable (also enables the FIFO)
//   fifo_empty - FIFO EMPTY flag
//   fifo_data  - FIFO dataOut, valid the cycle after fifo_rd is sampled high
//   fifo_rd    - one-cycle pop strobe into FIFO RD
// Modports: master = the drain (pops), slave = the FIFO side (supplies data/flags).
interface fifo_uart_tx_drain_if;
  logic        EN;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd;

  modport master (
    input  EN,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd
  );

  modport slave (
    output EN,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd
  );
endinterface

// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain: pops 32-bit words from a FIFO and sends each one as four 8N1 UART bytes, LSB byte first.
// Latency: IDLE decision in cycle 0, fifo_rd in cycle 1, latch in cycle 2, start bit from cycle 3. A word takes 4*(9+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: a pop happens only in IDLE with EN=1 and fifo_empty=0. A started word always completes, regardless of EN.
// Ports:
//   Clk, Rst   - clock; synchronous active-high reset
//   fifo       - FIFO read bundle (EN, fifo_empty, fifo_data in; fifo_rd out)
//   tx         - serial line, idles high
//   busy       - high from the pop request through the last stop bit of the word
//   word_done  - one-cycle pulse on the final cycle of byte 3's last stop bit
// Parameters: CLKS_PER_BIT in 2..65535, STOP_BITS in {1,2}.
module fifo_uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  fifo_uart_tx_drain_if.master  fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0]  state,     state_n;
  logic [15:0] baud_cnt,  baud_cnt_n;
  // Counts data bits in DATA and stop bits in STOP.
  logic [2:0]  bit_idx,   bit_idx_n;
  logic [1:0]  byte_idx,  byte_idx_n;
  // The byte on the wire is always in [7:0]. The register shifts right by 8 between bytes.
  logic [31:0] shift_reg, shift_reg_n;
  logic        fifo_rd_q, fifo_rd_n;
  logic        tx_n, busy_n, word_done_n;
  logic        bit_end;

  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign fifo.fifo_rd = fifo_rd_q;

  // Next-state logic. The baud counter is held at 0 outside the serial states.
  // This makes every entry into START, DATA or STOP begin a full bit period.
  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt + 16'd1;
    bit_idx_n   = bit_idx;
    byte_idx_n  = byte_idx;
    shift_reg_n = shift_reg;
    fifo_rd_n   = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_n = 16'd0;
        if (fifo.EN && !fifo.fifo_empty) begin
          state_n   = REQ;
          fifo_rd_n = 1'b1;
        end
      end

      REQ: begin
        baud_cnt_n = 16'd0;
        state_n    = LATCH;
      end

      // The FIFO's registered dataOut is valid now, one cycle after the pop.
      LATCH: begin
        baud_cnt_n  = 16'd0;
        shift_reg_n = fifo.fifo_data;
        byte_idx_n  = 2'd0;
        bit_idx_n   = 3'd0;
        state_n     = START;
      end

      START: begin
        if (bit_end) begin
          baud_cnt_n = 16'd0;
          bit_idx_n  = 3'd0;
          state_n    = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_n = 16'd0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_cnt_n = 16'd0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = 3'd0;
            if (byte_idx == 2'd3) begin
              state_n = IDLE;
            end else begin
              // The next start bit follows immediately, with no idle gap.
              byte_idx_n  = byte_idx + 2'd1;
              shift_reg_n = {8'h00, shift_reg[31:8]};
              state_n     = START;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      default: begin
        baud_cnt_n = 16'd0;
        state_n    = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values.
  // Each output then lines up with the state it describes, with no combinational path to the pins.
  always_comb begin
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n      = (state_n != IDLE);
    word_done_n = (state_n == STOP) && (byte_idx_n == 2'd3) &&
                  (bit_idx_n == STOP_LAST) && (baud_cnt_n == BAUD_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      byte_idx  <= 2'd0;
      fifo_rd_q <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      byte_idx  <= byte_idx_n;
      fifo_rd_q <= fifo_rd_n;
      tx        <= tx_n;
      busy      <= busy_n;
      word_done <= word_done_n;
    end
  end

  // The shift register is only meaningful after LATCH, so it carries no reset.
  always_ff @(posedge Clk) begin
    shift_reg <= shift_reg_n;
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Testbench for fifo_uart_tx_drain: two instances, A (CLKS_PER_BIT=4, STOP_BITS=1) and B (CLKS_PER_BIT=2, STOP_BITS=2).
// A word-FIFO model feeds A. Expected bytes are queued when words are pushed and popped as the serial line is decoded.
module tb_fifo_uart_tx_drain;

  logic Clk;
  logic Rst;
  logic tx_a, busy_a, wd_a;
  logic tx_b, busy_b, wd_b;

  fifo_uart_tx_drain_if ifa ();
  fifo_uart_tx_drain_if ifb ();

  fifo_uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .Clk       (Clk),
    .Rst       (Rst),
    .fifo      (ifa),
    .tx        (tx_a),
    .busy      (busy_a),
    .word_done (wd_a)
  );

  fifo_uart_tx_drain #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
    .Clk       (Clk),
    .Rst       (Rst),
    .fifo      (ifb),
    .tx        (tx_b),
    .busy      (busy_b),
    .word_done (wd_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] fq[$];
  logic [7:0]  exp_q[$];
  int          rd_ptr = 0;

  int   rd_cnt_a = 0, rd_last_a = -1, rd_dbl_a = 0, rd_cnt_b = 0;
  logic prev_rd_a = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO model for instance A: dataOut is updated during the pop cycle and is stable during LATCH.
  always @(negedge Clk) begin
    if (ifa.fifo_rd === 1'b1) begin
      if (rd_ptr < fq.size()) ifa.fifo_data <= fq[rd_ptr];
      else                    ifa.fifo_data <= 'x;
      rd_ptr         <= rd_ptr + 1;
      ifa.fifo_empty <= (rd_ptr + 1 >= fq.size());
    end else begin
      ifa.fifo_empty <= (rd_ptr >= fq.size());
    end
  end

  // Pop-strobe monitors.
  always @(negedge Clk) begin
    if (ifa.fifo_rd === 1'b1) begin
      rd_cnt_a  <= rd_cnt_a + 1;
      rd_last_a <= cyc;
      if (prev_rd_a) rd_dbl_a <= rd_dbl_a + 1;
    end
    prev_rd_a <= (ifa.fifo_rd === 1'b1);
    if (ifb.fifo_rd === 1'b1) rd_cnt_b <= rd_cnt_b + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  // Decodes one frame. The task returns at the negedge of the frame's last stop cycle.
  task automatic recv_byte(input bit sel_b, input int cpb, input int stop, input bit last,
                           output logic [7:0] val, output int s_cyc, output int e_cyc);
    int   waited = 0;
    int   errs   = 0;
    int   len;
    int   idx;
    logic t;
    val = 'x;
    @(negedge Clk);
    while ((sel_b ? tx_b : tx_a) !== 1'b0 && waited < 500) begin
      @(negedge Clk);
      waited++;
    end
    chk("start_bit_seen", (waited < 500), 1'b1);
    s_cyc = cyc;
    e_cyc = cyc;
    if (waited >= 500) return;
    len = (9 + stop) * cpb;
    for (int k = 1; k < len; k++) begin
      @(negedge Clk);
      t = sel_b ? tx_b : tx_a;
      if (k < cpb) begin
        if (t !== 1'b0) errs++;
      end else if (k < 9 * cpb) begin
        idx = k / cpb - 1;
        if (k % cpb == 0) val[idx] = t;
        else if (t !== val[idx]) errs++;
      end else if (t !== 1'b1) begin
        errs++;
      end
      if ((sel_b ? busy_b : busy_a) !== 1'b1) errs++;
      if (k < len - 1 && (sel_b ? wd_b : wd_a) !== 1'b0) errs++;
    end
    e_cyc = cyc;
    chk("frame_shape", errs, 0);
    chk("word_done_last_cycle", (sel_b ? wd_b : wd_a), last);
  endtask

  task automatic recv_word(input bit sel_b, input int cpb, input int stop,
                           output int s_first, output int e_last);
    logic [7:0] v;
    logic [7:0] expv;
    int s, e;
    int prev_e = 0;
    s_first = 0;
    for (int b = 0; b < 4; b++) begin
      recv_byte(sel_b, cpb, stop, (b == 3), v, s, e);
      if (b == 0) s_first = s;
      else        chk("byte_no_gap", s, prev_e + 1);
      if (exp_q.size() > 0) expv = exp_q.pop_front();
      else                  expv = 'x;
      chk("byte_data", v, expv);
      prev_e = e;
    end
    e_last = prev_e;
  endtask

  initial begin
    int r, c, n0, s, e, s1, e1, s2, e2, tl;
    logic [7:0] v;

    Rst = 1'b1;
    ifa.EN = 1'b0;
    ifb.EN = 1'b0;
    ifb.fifo_empty = 1'b1;
    ifb.fifo_data  = 32'h0;
    repeat (2) @(posedge Clk);

    // Reset held with a non-empty FIFO and EN high: outputs stay at rest.
    #1;
    ifa.EN = 1'b1;
    ifb.EN = 1'b1;
    ifb.fifo_empty = 1'b0;
    push_word(32'hA5C30F81);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("reset_outputs_a", {tx_a, ifa.fifo_rd, busy_a, wd_a}, 4'b1000);
      chk("reset_outputs_b", {tx_b, ifb.fifo_rd, busy_b, wd_b}, 4'b1000);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    ifb.EN = 1'b0;
    ifb.fifo_empty = 1'b1;
    r  = cyc;
    n0 = rd_cnt_a;

    // Single word 0xA5C30F81, decoded as 81 0F C3 A5.
    recv_word(1'b0, 4, 1, s, e);
    chk("first_rd_cycle", rd_last_a, r + 1);
    chk("first_start_cycle", s, r + 3);
    chk("word_done_cycle", e, r + 162);
    @(posedge Clk); #1;
    chk("single_rd_count", rd_cnt_a - n0, 1);

    // An empty FIFO with EN=1 gives no pop and an idle line.
    n0 = rd_cnt_a;
    tl = 0;
    repeat (50) begin
      @(negedge Clk);
      if (tx_a !== 1'b1) tl++;
    end
    @(posedge Clk); #1;
    chk("empty_no_rd", rd_cnt_a - n0, 0);
    chk("empty_tx_idle", tl, 0);

    // Back-to-back words.
    n0 = rd_cnt_a;
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    recv_word(1'b0, 4, 1, s1, e1);
    recv_word(1'b0, 4, 1, s2, e2);
    chk("b2b_idle_gap", s2 - e1 - 1, 3);
    chk("b2b_second_rd_cycle", rd_last_a, e1 + 2);
    @(posedge Clk); #1;
    chk("b2b_rd_count", rd_cnt_a - n0, 2);

    // EN=0 with a non-empty FIFO gives no pop.
    ifa.EN = 1'b0;
    push_word(32'h13579BDF);
    n0 = rd_cnt_a;
    repeat (30) @(negedge Clk);
    @(posedge Clk); #1;
    chk("en_low_no_rd", rd_cnt_a - n0, 0);

    // EN dropped during byte 1: the word completes, then no further fetch.
    ifa.EN = 1'b1;
    fork
      recv_word(1'b0, 4, 1, s1, e1);
      begin
        repeat (50) @(negedge Clk);
        @(posedge Clk); #1;
        ifa.EN = 1'b0;
        fq.push_back(32'h2460ACE0);
      end
    join
    tl = 0;
    repeat (40) begin
      @(negedge Clk);
      if (tx_a !== 1'b1) tl++;
    end
    @(posedge Clk); #1;
    chk("en_drop_single_fetch", rd_cnt_a - n0, 1);
    chk("en_drop_tx_idle", tl, 0);

    // Reset during DATA bit 3 of byte 2 of 0x2460ACE0 (byte 2 = 0x60, bit 3 = 0).
    for (int b = 0; b < 4; b++) exp_q.push_back(8'((32'h2460ACE0 >> (8 * b)) & 32'hFF));
    n0 = rd_cnt_a;
    ifa.EN = 1'b1;
    for (int b = 0; b < 2; b++) begin
      recv_byte(1'b0, 4, 1, 1'b0, v, s, e);
      chk("abort_word_byte", v, exp_q.pop_front());
    end
    @(negedge Clk);
    chk("byte2_start_bit", tx_a, 1'b0);
    repeat (16) @(negedge Clk);
    chk("byte2_bit3_low", tx_a, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_reset_outputs", {tx_a, busy_a, ifa.fifo_rd, wd_a}, 4'b1000);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tl = 0;
    repeat (10) begin
      @(negedge Clk);
      if (tx_a !== 1'b1) tl++;
    end
    chk("no_resume_after_reset", tl, 0);
    @(posedge Clk); #1;
    push_word(32'h0BADF00D);
    c = cyc;
    recv_word(1'b0, 4, 1, s, e);
    chk("fresh_word_start", s, c + 3);
    chk("fresh_word_rd_count", rd_cnt_a - n0, 2);

    // Instance B: two stop bits, CLKS_PER_BIT=2, word 0x12345678.
    ifb.fifo_data = 32'h12345678;
    for (int b = 0; b < 4; b++) exp_q.push_back(8'((32'h12345678 >> (8 * b)) & 32'hFF));
    @(posedge Clk); #1;
    ifb.fifo_empty = 1'b0;
    ifb.EN = 1'b1;
    c = cyc;
    fork
      recv_word(1'b1, 2, 2, s, e);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge Clk);
          if (ifb.fifo_rd === 1'b1) break;
        end
        ifb.fifo_empty = 1'b1;
      end
    join
    chk("b_start_cycle", s, c + 3);
    chk("b_word_span", e - s + 1, 88);
    @(posedge Clk); #1;
    chk("b_rd_count", rd_cnt_b, 1);

    chk("rd_never_consecutive", rd_dbl_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
